// File: rtl/fpga_hero_pkg.sv
// Shared constants, state encoding and helpers for the rhythm-game datapath.
package fpga_hero_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 2;

    // Game state encoding (legacy-compatible constants rather than an enum type)
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t RUN    = 2'd1;
    localparam state_t PAUSED = 2'd2;

    localparam logic [15:0] SCORE_MAX          = 16'hFFFF;
    localparam logic [7:0]  COMBO_MAX          = 8'hFF;
    localparam logic [7:0]  COMBO_BONUS_THRESH = 8'd8;

    // Number of set bits in a lane vector (at most NUM_LANES, fits in 3 bits)
    function automatic logic [2:0] lane_count(input logic [NUM_LANES-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/beat_tick_gen.sv
// Beat tick generator: free-running divider that counts only while enabled.
module beat_tick_gen #(
    parameter int unsigned TICK_DIV = 2500000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = enable && (cnt_q == LAST);

    // Count 0..TICK_DIV-1 while enabled, hold otherwise; clear restarts the beat
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/note_field_scroller.sv
// Note field scroller: spawns notes from the random source on each beat,
// scrolls them toward the hit row and judges lane button presses.
module note_field_scroller
    import fpga_hero_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TICK_DIV = 2500000,
    parameter int unsigned DENSITY  = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         pause,
    input  logic [6:0]                   rnd,
    input  logic [NUM_LANES-1:0]         buttons,
    output logic [NUM_LANES*DEPTH-1:0]   field,
    output logic                         hit,
    output logic                         miss,
    output logic [15:0]                  score,
    output logic [7:0]                   combo,
    output logic                         running
);

    localparam int unsigned FW = NUM_LANES * DEPTH;

    state_t                 state_q, state_d;
    logic [FW-1:0]          field_q, field_d;
    logic [15:0]            score_q, score_d;
    logic [7:0]             combo_q, combo_d;
    logic [NUM_LANES-1:0]   btn_q;
    logic [LANE_W-1:0]      last_lane_q;
    logic                   spawned_q;
    logic                   hit_q, miss_q;

    logic                   in_run;
    logic                   start_game;
    logic                   tick;
    logic                   spawn;
    logic [LANE_W-1:0]      lane_raw, lane;
    logic [NUM_LANES-1:0]   spawn_row;
    logic [NUM_LANES-1:0]   press, row0, hits, row0_post;
    logic                   wrong;
    logic                   missed;
    logic [2:0]             n_hits;
    logic [3:0]             score_inc;
    logic [16:0]            score_sum;
    logic [7:0]             combo_base;
    logic [8:0]             combo_sum;

    assign in_run     = (state_q == RUN);
    assign start_game = (state_q == IDLE) && start;

    beat_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (in_run),
        .clear  (start_game),
        .tick   (tick)
    );

    // Spawn decision and anti-repeat lane selection
    always_comb begin
        spawn     = ({1'b0, rnd} < 8'(DENSITY));
        lane_raw  = rnd[LANE_W-1:0];
        lane      = (spawned_q && (lane_raw == last_lane_q)) ? lane_raw + 1'b1 : lane_raw;
        spawn_row = '0;
        if (spawn) begin
            spawn_row[lane] = 1'b1;
        end
    end

    // Judge rising button edges against the pre-shift hit row
    always_comb begin
        press     = in_run ? (buttons & ~btn_q) : '0;
        row0      = field_q[NUM_LANES-1:0];
        hits      = press & row0;
        wrong     = |(press & ~row0);
        row0_post = row0 & ~hits;
        missed    = tick && (|row0_post);
        n_hits    = lane_count(hits);
    end

    // Game state transitions; only reset leaves RUN/PAUSED
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (pause) state_d = PAUSED;
            PAUSED:  if (!pause) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Field scroll, score and combo next-state
    always_comb begin
        field_d    = field_q;
        score_d    = score_q;
        combo_d    = combo_q;
        score_inc  = (combo_q >= COMBO_BONUS_THRESH) ? {n_hits, 1'b0} : {1'b0, n_hits};
        score_sum  = {1'b0, score_q} + 17'(score_inc);
        // A wrong press or a miss clears the combo before this cycle's hits add
        combo_base = (wrong || missed) ? 8'd0 : combo_q;
        combo_sum  = {1'b0, combo_base} + 9'(n_hits);
        if (start_game) begin
            field_d = '0;
            score_d = '0;
            combo_d = '0;
        end else if (in_run) begin
            field_d[NUM_LANES-1:0] = row0_post;
            if (tick) begin
                field_d = {spawn_row, field_q[FW-1:NUM_LANES]};
            end
            score_d = score_sum[16] ? SCORE_MAX : score_sum[15:0];
            combo_d = combo_sum[8] ? COMBO_MAX : combo_sum[7:0];
        end
    end

    // State registers; button history tracks in every state so held presses never re-trigger
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            field_q     <= '0;
            score_q     <= '0;
            combo_q     <= '0;
            btn_q       <= '0;
            last_lane_q <= '0;
            spawned_q   <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            score_q <= score_d;
            combo_q <= combo_d;
            btn_q   <= buttons;
            hit_q   <= |hits;
            miss_q  <= missed;
            if (tick) begin
                last_lane_q <= lane;
                spawned_q   <= spawn;
            end
        end
    end

    assign field   = field_q;
    assign hit     = hit_q;
    assign miss    = miss_q;
    assign score   = score_q;
    assign combo   = combo_q;
    assign running = in_run;

endmodule

// File: tb/tb_note_field_scroller.sv
// Directed bench for note_field_scroller with DEPTH=4, TICK_DIV=4, DENSITY=64.
module tb_note_field_scroller;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DENSITY  = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        pause;
    logic [6:0]  rnd;
    logic [3:0]  buttons;
    logic [15:0] field;
    logic        hit;
    logic        miss;
    logic [15:0] score;
    logic [7:0]  combo;
    logic        running;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    note_field_scroller #(
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV),
        .DENSITY  (DENSITY)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .pause   (pause),
        .rnd     (rnd),
        .buttons (buttons),
        .field   (field),
        .hit     (hit),
        .miss    (miss),
        .score   (score),
        .combo   (combo),
        .running (running)
    );

    // One beat period of stimulus and the state expected after its tick edge
    typedef struct {
        bit          restart;
        logic [6:0]  rnd;
        logic [3:0]  press;
        bit          late;
        logic [15:0] field;
        int          hits;
        int          misses;
        logic [15:0] score;
        logic [7:0]  combo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rs, input logic [6:0] r, input logic [3:0] p, input bit l,
                       input logic [15:0] f, input int h, input int m,
                       input logic [15:0] s, input logic [7:0] c);
        vec_t v;
        v.restart = rs; v.rnd = r; v.press = p; v.late = l;
        v.field = f; v.hits = h; v.misses = m; v.score = s; v.combo = c;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reset, then start: leaves the beat counter at 0 just after the start edge
    task automatic restart();
        reset = 1'b1; start = 1'b0; pause = 1'b0; buttons = 4'h0; rnd = 7'h7F;
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Run one full beat period; press in the first cycle, or in the tick cycle when late
    task automatic run_tick(input logic [6:0] r, input logic [3:0] p, input bit late,
                            output int hc, output int mc);
        hc = 0;
        mc = 0;
        rnd = r;
        for (int c = 0; c < TICK_DIV; c++) begin
            buttons = ((late && c == TICK_DIV - 1) || (!late && c == 0)) ? p : 4'h0;
            step();
            if (hit)  hc++;
            if (miss) mc++;
        end
        buttons = 4'h0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int hc, mc;

        reset = 1'b1; start = 1'b0; pause = 1'b0; rnd = 7'h00; buttons = 4'h0;
        step();
        step();
        chk("reset_field", 32'(field), 32'h0);
        chk("reset_score", 32'(score), 32'h0);
        chk("reset_combo", 32'(combo), 32'h0);
        chk("reset_hit", 32'(hit), 32'h0);
        chk("reset_miss", 32'(miss), 32'h0);
        chk("reset_running", 32'(running), 32'h0);
        reset = 1'b0;
        step();
        chk("idle_running", 32'(running), 32'h0);

        // No spawn: rnd=80 is above the density threshold
        add(1, 7'h50, 4'h0, 0, 16'h0000, 0, 0, 16'd0, 8'd0);
        for (int i = 0; i < 9; i++) add(0, 7'h50, 4'h0, 0, 16'h0000, 0, 0, 16'd0, 8'd0);
        // Miss path with anti-repeat alternating lanes 1,2
        add(1, 7'h05, 4'h0, 0, 16'h2000, 0, 0, 16'd0, 8'd0);
        add(0, 7'h05, 4'h0, 0, 16'h4200, 0, 0, 16'd0, 8'd0);
        add(0, 7'h05, 4'h0, 0, 16'h2420, 0, 0, 16'd0, 8'd0);
        add(0, 7'h05, 4'h0, 0, 16'h4242, 0, 0, 16'd0, 8'd0);
        add(0, 7'h05, 4'h0, 0, 16'h2424, 0, 1, 16'd0, 8'd0);
        add(0, 7'h05, 4'h0, 0, 16'h4242, 0, 1, 16'd0, 8'd0);
        // Density boundary: 63 spawns in lane 3, 64 does not
        add(1, 7'h40, 4'h0, 0, 16'h0000, 0, 0, 16'd0, 8'd0);
        add(0, 7'h3F, 4'h0, 0, 16'h8000, 0, 0, 16'd0, 8'd0);
        add(0, 7'h3F, 4'h0, 0, 16'h1800, 0, 0, 16'd0, 8'd0);
        add(0, 7'h40, 4'h0, 0, 16'h0180, 0, 0, 16'd0, 8'd0);
        add(0, 7'h3F, 4'h0, 0, 16'h8018, 0, 0, 16'd0, 8'd0);
        add(0, 7'h40, 4'h0, 0, 16'h0801, 0, 1, 16'd0, 8'd0);
        // Single hit, then a wrong press on an empty hit row
        add(1, 7'h05, 4'h0, 0, 16'h2000, 0, 0, 16'd0, 8'd0);
        add(0, 7'h50, 4'h0, 0, 16'h0200, 0, 0, 16'd0, 8'd0);
        add(0, 7'h50, 4'h0, 0, 16'h0020, 0, 0, 16'd0, 8'd0);
        add(0, 7'h50, 4'h0, 0, 16'h0002, 0, 0, 16'd0, 8'd0);
        add(0, 7'h50, 4'h2, 0, 16'h0000, 1, 0, 16'd1, 8'd1);
        add(0, 7'h50, 4'h0, 0, 16'h0000, 0, 0, 16'd1, 8'd1);
        add(0, 7'h50, 4'h1, 0, 16'h0000, 0, 0, 16'd1, 8'd0);
        // Press in the tick cycle: judged on pre-shift row 0, no miss
        add(1, 7'h3F, 4'h0, 0, 16'h8000, 0, 0, 16'd0, 8'd0);
        add(0, 7'h40, 4'h0, 0, 16'h0800, 0, 0, 16'd0, 8'd0);
        add(0, 7'h40, 4'h0, 0, 16'h0080, 0, 0, 16'd0, 8'd0);
        add(0, 7'h40, 4'h0, 0, 16'h0008, 0, 0, 16'd0, 8'd0);
        add(0, 7'h40, 4'h8, 1, 16'h0000, 1, 0, 16'd1, 8'd1);
        // Combo bonus: nine hits give 8x1 + 1x2
        add(1, 7'h01, 4'h0, 0, 16'h2000, 0, 0, 16'd0, 8'd0);
        add(0, 7'h01, 4'h0, 0, 16'h4200, 0, 0, 16'd0, 8'd0);
        add(0, 7'h01, 4'h0, 0, 16'h2420, 0, 0, 16'd0, 8'd0);
        add(0, 7'h01, 4'h0, 0, 16'h4242, 0, 0, 16'd0, 8'd0);
        for (int k = 1; k <= 8; k++) begin
            add(0, 7'h01, (k % 2 == 1) ? 4'h2 : 4'h4, 0, (k % 2 == 1) ? 16'h2424 : 16'h4242,
                1, 0, 16'(k), 8'(k));
        end
        add(0, 7'h01, 4'h2, 0, 16'h2424, 1, 0, 16'd10, 8'd9);
        // Hit plus wrong press: combo restarts at the hit count, bonus still applies
        add(0, 7'h01, 4'h5, 0, 16'h4242, 1, 0, 16'd12, 8'd1);
        // Wrong press while the row-0 note leaves: miss, combo cleared, score held
        add(0, 7'h01, 4'h8, 0, 16'h2424, 0, 1, 16'd12, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].restart) begin
                restart();
                chk($sformatf("v%0d_running", i), 32'(running), 32'h1);
            end
            run_tick(vecs[i].rnd, vecs[i].press, vecs[i].late, hc, mc);
            chk($sformatf("v%0d_field", i), 32'(field), 32'(vecs[i].field));
            chk($sformatf("v%0d_hits", i), 32'(hc), 32'(vecs[i].hits));
            chk($sformatf("v%0d_misses", i), 32'(mc), 32'(vecs[i].misses));
            chk($sformatf("v%0d_score", i), 32'(score), 32'(vecs[i].score));
            chk($sformatf("v%0d_combo", i), 32'(combo), 32'(vecs[i].combo));
        end

        // Pause: field and beat counter freeze, held press gives no edge on resume
        restart();
        run_tick(7'h05, 4'h0, 0, hc, mc);
        run_tick(7'h50, 4'h0, 0, hc, mc);
        run_tick(7'h50, 4'h0, 0, hc, mc);
        run_tick(7'h50, 4'h0, 0, hc, mc);
        run_tick(7'h50, 4'h2, 0, hc, mc);
        chk("pre_pause_score", 32'(score), 32'd1);
        run_tick(7'h05, 4'h0, 0, hc, mc);
        run_tick(7'h50, 4'h0, 0, hc, mc);
        run_tick(7'h50, 4'h0, 0, hc, mc);
        run_tick(7'h50, 4'h0, 0, hc, mc);
        chk("pre_pause_field", 32'(field), 32'h0002);
        pause = 1'b1;
        step();
        buttons = 4'h2;
        chk("pause_running", 32'(running), 32'h0);
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("pause%0d_field", k), 32'(field), 32'h0002);
            chk($sformatf("pause%0d_hit", k), 32'(hit), 32'h0);
            chk($sformatf("pause%0d_running", k), 32'(running), 32'h0);
        end
        pause = 1'b0;
        step();
        chk("resume_running", 32'(running), 32'h1);
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("resume%0d_field", k), 32'(field), 32'h0002);
            chk($sformatf("resume%0d_hit", k), 32'(hit), 32'h0);
        end
        step();
        chk("resume_tick_field", 32'(field), 32'h0000);
        chk("resume_tick_miss", 32'(miss), 32'h1);
        chk("resume_tick_hit", 32'(hit), 32'h0);
        chk("resume_tick_combo", 32'(combo), 32'h0);
        chk("resume_tick_score", 32'(score), 32'd1);
        buttons = 4'h0;
        run_tick(7'h05, 4'h0, 0, hc, mc);
        chk("pre_reset_field", 32'(field), 32'h2000);

        // Reset mid-run returns to IDLE with everything cleared
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_field", 32'(field), 32'h0);
        chk("midreset_score", 32'(score), 32'h0);
        chk("midreset_combo", 32'(combo), 32'h0);
        chk("midreset_running", 32'(running), 32'h0);
        for (int k = 0; k < 6; k++) step();
        chk("idle_hold_running", 32'(running), 32'h0);
        chk("idle_hold_field", 32'(field), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_field_scroller.md
Name: note_field_scroller

Overview:
Gameplay stage directly downstream of the 7-bit pseudo-random source. On each beat tick it consumes one random value and decides whether to spawn a note, and in which of 4 lanes. It scrolls a DEPTH-row note field toward the hit row and judges player button presses against that row. Outputs feed the display renderer (field bitmap) and the score/HUD logic (hit/miss pulses, score, combo).

Parameters:
DEPTH, 16, rows per lane; row 0 is the hit row, row DEPTH-1 is the spawn row
TICK_DIV, 2500000, clock cycles per beat tick (20 Hz at 50 MHz); minimum 2
DENSITY, 64, spawn threshold; a note spawns when rnd < DENSITY (0..128)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  pulse; begins a game from IDLE
pause  in  1  level; freezes play while high
rnd  in  7  free-running random value; sampled only on tick
buttons  in  4  lane buttons, already synchronised and debounced, active-high
field  out  4*DEPTH  note bitmap; bit [r*4+l] = note at row r, lane l
hit  out  1  one-cycle pulse per cycle with ≥1 successful hit
miss  out  1  one-cycle pulse per tick on which ≥1 unhit note leaves row 0
score  out  16  saturating at 16'hFFFF
combo  out  8  saturating at 255
running  out  1  high in RUN

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-high, and is honoured at any time, including mid-game. Reset clears state to IDLE, field, score, combo, tick counter, button history, and last-lane register to 0. All outputs are 0 after reset.
- States:
  - IDLE: start moves to RUN. On that edge, field, score, combo, and tick counter clear.
  - RUN: pause=1 moves to PAUSED.
  - PAUSED: pause=0 returns to RUN.
  - start is ignored outside IDLE. There is no return to IDLE except by reset.
- Tick: counter runs 0..TICK_DIV-1 only in RUN and holds in PAUSED. tick is asserted in the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
- Spawn, evaluated on tick only:
  - spawn = (rnd < DENSITY); lane = rnd[1:0].
  - Anti-repeat: if the previous tick spawned and lane equals last_lane, use lane = (lane+1) mod 4.
  - New spawn row = one-hot(lane) if spawn, else 0. last_lane and the spawned flag are updated on every tick.
- Scroll, on tick: row[i] <= row[i+1]; row[DEPTH-1] <= spawn row.
  - Any note in post-judge row 0 is discarded.
  - If any such note existed, miss pulses and combo clears to 0.
- Judge, RUN only:
  - edge = buttons & ~btn_q. btn_q updates every cycle in all states, so presses held across a pause produce no edge on resume.
  - For each lane with an edge: if row0[lane]=1 it is a hit and row0[lane] clears; otherwise it is a wrong press.
  - Results register on the same edge, so hit pulses in the cycle after buttons is first seen high.
- Scoring per cycle, with n = number of hits:
  - Each hit adds 2 if combo (pre-update) ≥ 8, else 1.
  - combo_next = (wrong press ? 0 : combo) + n, saturating at 255. score saturates at 16'hFFFF.
- Simultaneous tick and button edge: judge uses the pre-shift row 0. A note hit that cycle does not also produce a miss. Shift and judge commit on the same edge.
- Simultaneous miss and hit on one tick: both pulses assert. combo = n (miss clears first, then hits add).
- PAUSED: field, counter, score, and combo are frozen; button edges are ignored; running=0.

Decomposition:
- Shared package fpga_hero_pkg:
  - NUM_LANES=4, LANE_W=2
  - state enum {IDLE, RUN, PAUSED}
  - SCORE_MAX, COMBO_MAX, COMBO_BONUS_THRESH=8
- Sub-module beat_tick_gen (parameter TICK_DIV; inputs clock, reset, enable, clear; output tick). Reused by the audio/tempo logic.

Test Plan (DEPTH=4, TICK_DIV=4, DENSITY=64):
- Miss path: reset, start, rnd=7'h05 held. Tick 1 → field row3=4'b0010. After 4 ticks it reaches row0. On tick 5, miss=1 for one cycle and combo=0.
- No-spawn path: rnd=7'h50 (80 ≥ 64) held for 10 ticks → field stays all zero, no hit/miss pulses.
- Single hit: with a note at row0 lane1, raise buttons=4'b0010 → hit=1 in the next cycle, score=1, combo=1, row0 cleared, no miss on the following tick.
- Anti-repeat: rnd=7'h01 held → spawned lanes alternate 1,2,1,2 across consecutive ticks.
- Combo bonus: hit 9 consecutive notes → score=10 (8×1 + 1×2), combo=9. A wrong press on an empty row0 then sets combo=0 and leaves score=10.
- Pause and reset:
  - Assert pause for 10 cycles mid-run → field and counter unchanged, and a button pressed during pause yields no hit after release of pause.
  - Then assert reset in RUN → next cycle IDLE, field/score/combo=0, running=0.
